i2c_ram_arbiter: RTL

Arbitrates a single-port synchronous block RAM between the I2C register-slave register port and a local host port. The I2C side has fixed priority because the bus slave cannot be stalled. The host side uses a req/ack handshake. The block sits between the I2C register slave and the RAM, and drives every RAM port.

---
 rtl/i2c_ram_arb_pkg.sv | 30 +++
 rtl/i2c_ram_arb_pend.sv | 78 +++++++
 rtl/i2c_ram_arbiter.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/i2c_ram_arb_pkg.sv
// Shared types for the I2C/host single-port RAM arbiter.
// The write-protect option is selected by I2C_RAM_ARB_WRPROT_EN.
package i2c_ram_arb_pkg;

  localparam int PROT_CNT_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    I2C_RD   = 2'd1,
    HOST_RD  = 2'd2,
    HOST_ACK = 2'd3
  } arbState_e;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } slotOp_e;

  // Saturating increment for the dropped-write counter
  function automatic logic [PROT_CNT_WIDTH-1:0] satInc(input logic [PROT_CNT_WIDTH-1:0] v);
    logic [PROT_CNT_WIDTH-1:0] r;
    if (v == {PROT_CNT_WIDTH{1'b1}}) begin
      r = v;
    end else begin
      r = v + PROT_CNT_WIDTH'(1);
    end
    return r;
  endfunction

endpackage

// File: rtl/i2c_ram_arb_pend.sv
// Single-entry pending slot for I2C strobes with sticky overflow detection.
// A strobe is accepted when the slot is empty or being consumed in the same cycle.
module i2c_ram_arb_pend
  import i2c_ram_arb_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              sRst,
  input  logic [ADDR_W-1:0] i2cAddr,
  input  logic              i2cWrEn,
  input  logic [DATA_W-1:0] i2cWrData,
  input  logic              i2cRdEn,
  input  logic              consume,
  output logic              slotValid,
  output slotOp_e           slotOp,
  output logic [ADDR_W-1:0] slotAddr,
  output logic [DATA_W-1:0] slotData,
  output logic              ovfErr
);

  typedef struct packed {
    slotOp_e             op;
    logic [ADDR_W-1:0]   addr;
    logic [DATA_W-1:0]   data;
  } pendSlot_t;

  pendSlot_t slot_r, slotNext_s;
  logic      valid_r, validNext_s;
  logic      ovf_r, ovfNext_s;
  logic      strobe_s, accept_s;

  // Slot load/clear and overflow flag update
  always_comb begin
    strobe_s    = i2cWrEn | i2cRdEn;
    accept_s    = strobe_s & (~valid_r | consume);
    slotNext_s  = slot_r;
    validNext_s = valid_r;
    ovfNext_s   = ovf_r;
    if (accept_s) begin
      // a simultaneous read strobe loses to the write
      slotNext_s.op   = i2cWrEn ? OP_WR : OP_RD;
      slotNext_s.addr = i2cAddr;
      slotNext_s.data = i2cWrData;
      validNext_s     = 1'b1;
    end else if (consume) begin
      validNext_s = 1'b0;
    end else begin
      validNext_s = valid_r;
    end
    if ((strobe_s & ~accept_s) | (i2cWrEn & i2cRdEn)) begin
      ovfNext_s = 1'b1;
    end else begin
      ovfNext_s = ovf_r;
    end
  end

  // Slot and flag registers
  always_ff @(posedge clk) begin
    if (sRst) begin
      slot_r  <= '0;
      valid_r <= 1'b0;
      ovf_r   <= 1'b0;
    end else begin
      slot_r  <= slotNext_s;
      valid_r <= validNext_s;
      ovf_r   <= ovfNext_s;
    end
  end

  assign slotValid = valid_r;
  assign slotOp    = slot_r.op;
  assign slotAddr  = slot_r.addr;
  assign slotData  = slot_r.data;
  assign ovfErr    = ovf_r;

endmodule

// File: rtl/i2c_ram_arbiter.sv
// Single-port RAM arbiter: I2C register slave has fixed priority, host uses req/ack.
// Define I2C_RAM_ARB_WRPROT_EN to drop I2C writes at or above PROT_BASE_P.
module i2c_ram_arbiter
  import i2c_ram_arb_pkg::*;
#(
  parameter int TPD_P       = 2,
  parameter int RAM_WIDTH_P = 32,
  parameter int RAM_DEPTH_P = 1024,
  parameter int PROT_BASE_P = 768,
  localparam int AW         = $clog2(RAM_DEPTH_P)
) (
  input  logic                      clk,
  input  logic                      sRst,
  input  logic [AW-1:0]             i2cAddr,
  input  logic                      i2cWrEn,
  input  logic [RAM_WIDTH_P-1:0]    i2cWrData,
  input  logic                      i2cRdEn,
  output logic [RAM_WIDTH_P-1:0]    i2cRdData,
  input  logic                      hostReq,
  input  logic                      hostWe,
  input  logic [AW-1:0]             hostAddr,
  input  logic [RAM_WIDTH_P-1:0]    hostWrData,
  output logic                      hostAck,
  output logic [RAM_WIDTH_P-1:0]    hostRdData,
  output logic [AW-1:0]             ramAddr,
  output logic                      ramWrEn,
  output logic [RAM_WIDTH_P-1:0]    ramWrData,
  input  logic [RAM_WIDTH_P-1:0]    ramRdData,
  output logic                      ovfErr,
  output logic [PROT_CNT_WIDTH-1:0] protDropCnt
);

  // Parameter sanity hook; the clock-to-out delay is a simulation-only attribute.
  if (TPD_P < 0 || PROT_BASE_P > RAM_DEPTH_P) begin : gBadParams
  end

  arbState_e               state_r, stateNext_s;
  logic                    consume_s;
  logic                    slotValid_s;
  slotOp_e                 slotOp_s;
  logic [AW-1:0]           slotAddr_s;
  logic [RAM_WIDTH_P-1:0]  slotData_s;
  logic                    protHit_s;

  i2c_ram_arb_pend #(
    .ADDR_W (AW),
    .DATA_W (RAM_WIDTH_P)
  ) uPend (
    .clk       (clk),
    .sRst      (sRst),
    .i2cAddr   (i2cAddr),
    .i2cWrEn   (i2cWrEn),
    .i2cWrData (i2cWrData),
    .i2cRdEn   (i2cRdEn),
    .consume   (consume_s),
    .slotValid (slotValid_s),
    .slotOp    (slotOp_s),
    .slotAddr  (slotAddr_s),
    .slotData  (slotData_s),
    .ovfErr    (ovfErr)
  );

  // Next state and RAM port drive; idle RAM ports are forced to zero
  always_comb begin
    stateNext_s = state_r;
    consume_s   = 1'b0;
    ramAddr     = '0;
    ramWrEn     = 1'b0;
    ramWrData   = '0;
    case (state_r)
      IDLE: begin
        if (slotValid_s) begin
          consume_s = 1'b1;
          if (slotOp_s == OP_RD) begin
            ramAddr     = slotAddr_s;
            stateNext_s = I2C_RD;
          end else if (protHit_s) begin
            ramWrEn = 1'b0;
          end else begin
            ramAddr   = slotAddr_s;
            ramWrEn   = 1'b1;
            ramWrData = slotData_s;
          end
        end else if (hostReq) begin
          ramAddr = hostAddr;
          if (hostWe) begin
            ramWrEn     = 1'b1;
            ramWrData   = hostWrData;
            stateNext_s = HOST_ACK;
          end else begin
            stateNext_s = HOST_RD;
          end
        end else begin
          stateNext_s = IDLE;
        end
      end
      I2C_RD:   stateNext_s = IDLE;
      HOST_RD:  stateNext_s = HOST_ACK;
      HOST_ACK: stateNext_s = IDLE;
      default:  stateNext_s = IDLE;
    endcase
  end

  // State, read-data capture and registered ack pulse
  always_ff @(posedge clk) begin
    if (sRst) begin
      state_r    <= IDLE;
      i2cRdData  <= '0;
      hostRdData <= '0;
      hostAck    <= 1'b0;
    end else begin
      state_r <= stateNext_s;
      hostAck <= (stateNext_s == HOST_ACK);
      if (state_r == I2C_RD) begin
        i2cRdData <= ramRdData;
      end
      if (state_r == HOST_RD) begin
        hostRdData <= ramRdData;
      end
    end
  end

`ifdef I2C_RAM_ARB_WRPROT_EN
  localparam logic [AW-1:0] PROT_BASE_A = AW'(PROT_BASE_P);
  logic [PROT_CNT_WIDTH-1:0] protDropCnt_r;

  assign protHit_s = (slotOp_s == OP_WR) && (slotAddr_s >= PROT_BASE_A);

  // Count I2C writes dropped by the protection window
  always_ff @(posedge clk) begin
    if (sRst) begin
      protDropCnt_r <= '0;
    end else if (consume_s && protHit_s) begin
      protDropCnt_r <= satInc(protDropCnt_r);
    end else begin
      protDropCnt_r <= protDropCnt_r;
    end
  end

  assign protDropCnt = protDropCnt_r;
`else
  assign protHit_s   = 1'b0;
  assign protDropCnt = '0;
`endif

endmodule
